// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-format defaults
// common to the transmit and receive sides.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Received-byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 rdy;
    logic                 frame_err;
    logic                 overrun;
    logic                 rx_busy;
    logic                 rdy_clr;

    modport master (
        output data_out, rdy, frame_err, overrun, rx_busy,
        input  rdy_clr
    );

    modport slave (
        input  data_out, rdy, frame_err, overrun, rx_busy,
        output rdy_clr
    );
endinterface

// File: rtl/uart_sync_bit.sv
// Multi-flop synchronizer bringing one asynchronous bit into the clk domain.
module uart_sync_bit #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the chain; the reset value matches the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes Rx, finds the start bit, samples each bit at
// its centre using the oversampling tick, and holds the byte for the consumer.
// DATA_BITS must be at least 2.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_50m,
    input  logic            rst_n,
    input  logic            Rx,
    input  logic            rx_clken,
    uart_receiver_if.master bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_s;

    uart_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .d_i   (Rx),
        .q_o   (rx_s)
    );

    // State, counters, shift register and output flags.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic; rdy_clr clears the flags first so a same-cycle set wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = rdy_q  & ~bus.rdy_clr;
        ferr_d  = ferr_q & ~bus.rdy_clr;
        ovr_d   = ovr_q  & ~bus.rdy_clr;

        case (state_q)
            IDLE: begin
                if (rx_clken && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (rx_clken) begin
                    if (cnt_q == CNT_HALF) begin
                        // Still low at mid start bit: real frame, now bit-centre aligned.
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (rx_clken) begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = STOP;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (rx_clken) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            data_d  = shift_q;
                            rdy_d   = 1'b1;
                            ovr_d   = ovr_d | rdy_q;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BRK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            BRK: begin
                if (rx_clken && rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.rx_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: bench-driven 8N1 frames aligned to a
// 27-cycle tick, with a scoreboard monitor checking every byte/flag event.
module tb_uart_receiver;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       Rx      = 1'b1;
    logic       rx_clken = 1'b0;
    logic [4:0] tdiv    = 5'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       rdy;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t sb_q[$];

    uart_receiver_if #(.DATA_BITS(8)) bus ();

    uart_receiver #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .Rx       (Rx),
        .rx_clken (rx_clken),
        .bus      (bus)
    );

    always #10 clk_50m = ~clk_50m;

    always @(posedge clk_50m) begin
        if (tdiv == 5'd26) begin
            tdiv     <= 5'd0;
            rx_clken <= 1'b1;
        end else begin
            tdiv     <= tdiv + 5'd1;
            rx_clken <= 1'b0;
        end
    end

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk_50m);
            while (!rx_clken) @(posedge clk_50m);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk_50m);
        bus.rdy_clr = 1'b1;
        @(negedge clk_50m);
        bus.rdy_clr = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic r, input logic f, input logic o);
        exp_t e;
        e.data = d;
        e.rdy  = r;
        e.ferr = f;
        e.ovr  = o;
        sb_q.push_back(e);
    endtask

    // Sends one frame; Rx is left at the stop-bit level. With clr_at_stop the
    // rdy_clr pulse lands exactly on the tick that samples the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit clr_at_stop);
        wait_ticks(1);
        @(negedge clk_50m);
        Rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_50m);
            Rx = b[i];
            wait_ticks(16);
        end
        @(negedge clk_50m);
        Rx = stop;
        wait_ticks(8);
        if (clr_at_stop) begin
            repeat (26) @(posedge clk_50m);
            @(negedge clk_50m);
            bus.rdy_clr = 1'b1;
            @(posedge clk_50m);
            @(negedge clk_50m);
            bus.rdy_clr = 1'b0;
        end else begin
            wait_ticks(1);
        end
        wait_ticks(7);
    endtask

    logic       rdy_p  = 1'b0;
    logic       ferr_p = 1'b0;
    logic       ovr_p  = 1'b0;
    logic [7:0] data_p = 8'h00;

    // Monitor: any new byte or rising flag is an output event checked against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_50m);
            if (rst_n && ((bus.rdy && !rdy_p) || (bus.rdy && bus.data_out != data_p) ||
                          (bus.frame_err && !ferr_p) || (bus.overrun && !ovr_p))) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got data 0x%0h rdy %0b ferr %0b ovr %0b, no entry expected",
                             bus.data_out, bus.rdy, bus.frame_err, bus.overrun);
                end else begin
                    e = sb_q.pop_front();
                    chk8("sb_data", bus.data_out, e.data);
                    chk1("sb_rdy", bus.rdy, e.rdy);
                    chk1("sb_frame_err", bus.frame_err, e.ferr);
                    chk1("sb_overrun", bus.overrun, e.ovr);
                end
            end
            rdy_p  = bus.rdy;
            ferr_p = bus.frame_err;
            ovr_p  = bus.overrun;
            data_p = bus.data_out;
        end
    end

    initial begin
        repeat (90000) @(posedge clk_50m);
        $display("FAIL watchdog: got no end of test, required completion within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] lb [3];
        bit         fell;
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h55;
        bus.rdy_clr = 1'b0;

        // 1: reset and idle line
        repeat (5) @(negedge clk_50m);
        rst_n = 1'b1;
        wait_ticks(200);
        @(negedge clk_50m);
        chk1("idle_rdy", bus.rdy, 1'b0);
        chk1("idle_frame_err", bus.frame_err, 1'b0);
        chk1("idle_overrun", bus.overrun, 1'b0);
        chk1("idle_rx_busy", bus.rx_busy, 1'b0);
        chk8("idle_data", bus.data_out, 8'h00);

        // 2: good frame 0xA5, then clear
        push_exp(8'hA5, 1'b1, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b0);
        @(negedge clk_50m);
        chk1("a5_rdy", bus.rdy, 1'b1);
        pulse_clr();
        chk1("a5_clr_rdy", bus.rdy, 1'b0);
        chk8("a5_clr_data", bus.data_out, 8'hA5);

        // 3: short glitch on the line
        wait_ticks(1);
        @(negedge clk_50m);
        Rx = 1'b0;
        wait_ticks(2);
        @(negedge clk_50m);
        chk1("glitch_busy", bus.rx_busy, 1'b1);
        wait_ticks(2);
        @(negedge clk_50m);
        Rx = 1'b1;
        fell = 1'b0;
        for (int i = 0; i < 8 && !fell; i++) begin
            wait_ticks(1);
            @(negedge clk_50m);
            if (!bus.rx_busy) fell = 1'b1;
        end
        chk1("glitch_busy_fell", fell, 1'b1);
        chk1("glitch_rdy", bus.rdy, 1'b0);
        chk1("glitch_frame_err", bus.frame_err, 1'b0);

        // 4: framing error, held break, recovery frame
        push_exp(8'hA5, 1'b0, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        pulse_clr();
        wait_ticks(40);
        @(negedge clk_50m);
        chk1("brk_no_second_err", bus.frame_err, 1'b0);
        chk1("brk_busy", bus.rx_busy, 1'b1);
        Rx = 1'b1;
        wait_ticks(4);
        @(negedge clk_50m);
        chk1("brk_exit_busy", bus.rx_busy, 1'b0);
        chk8("brk_data_kept", bus.data_out, 8'hA5);
        push_exp(8'h7E, 1'b1, 1'b0, 1'b0);
        send_byte(8'h7E, 1'b1, 1'b0);
        @(negedge clk_50m);
        chk1("7e_rdy", bus.rdy, 1'b1);
        pulse_clr();

        // 5: overrun, with rdy_clr colliding with the second rdy set
        push_exp(8'h11, 1'b1, 1'b0, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        push_exp(8'h22, 1'b1, 1'b0, 1'b1);
        send_byte(8'h22, 1'b1, 1'b1);
        @(negedge clk_50m);
        chk8("ovr_data", bus.data_out, 8'h22);
        chk1("ovr_rdy", bus.rdy, 1'b1);
        chk1("ovr_overrun", bus.overrun, 1'b1);

        // 6: reset in the middle of a frame (bit 3), then a clean frame
        wait_ticks(1);
        @(negedge clk_50m);
        Rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50m);
            Rx = 1'b1;
            wait_ticks(16);
        end
        @(negedge clk_50m);
        Rx = 1'b0;
        wait_ticks(8);
        @(negedge clk_50m);
        rst_n = 1'b0;
        #1;
        chk8("rst_data", bus.data_out, 8'h00);
        chk1("rst_rdy", bus.rdy, 1'b0);
        chk1("rst_frame_err", bus.frame_err, 1'b0);
        chk1("rst_overrun", bus.overrun, 1'b0);
        chk1("rst_rx_busy", bus.rx_busy, 1'b0);
        Rx = 1'b1;
        repeat (5) @(negedge clk_50m);
        rst_n = 1'b1;
        wait_ticks(20);
        push_exp(8'h5A, 1'b1, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b0);
        @(negedge clk_50m);
        chk1("5a_overrun", bus.overrun, 1'b0);
        pulse_clr();

        // Loopback bytes from the bench transmitter model
        for (int i = 0; i < 3; i++) begin
            push_exp(lb[i], 1'b1, 1'b0, 1'b0);
            send_byte(lb[i], 1'b1, 1'b0);
            @(negedge clk_50m);
            chk8("loop_data", bus.data_out, lb[i]);
            pulse_clr();
        end

        wait_ticks(4);
        chk8("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
